node_mu_ctrl: RTL and testbench

//  Initiator side of the node ST/RD/RES handshake: a minimization (mu-operator) node of the

---
 rtl/node_mu_ctrl_pkg.sv | 16 +
 rtl/node_mu_ctrl_st_edge.sv | 21 ++
 rtl/node_mu_ctrl.sv | 155 +++++++++++++++
 tb/tb_node_mu_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_mu_ctrl_pkg.sv
// Shared definitions for the tree-parser control nodes: default data width and
// the controller state encoding.
package node_mu_ctrl_pkg;

  localparam int NODE_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    EVAL      = 3'd4,
    GAP       = 3'd5
  } node_state_t;

endpackage

// File: rtl/node_mu_ctrl_st_edge.sv
// Registered previous value of a level plus a combinational rising-edge pulse.
// RESET_VAL picks what "previous" reads as right after reset.
module node_mu_ctrl_st_edge #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise
);

  logic dOld;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) dOld <= RESET_VAL;
    else      dOld <= d;
  end

  assign rise = d & ~dOld;

endmodule

// File: rtl/node_mu_ctrl.sv
// Mu-operator tree node: starts one child with Y = 0,1,2,... and returns the
// first Y whose child result is zero (OVF when MAX_ITER is exhausted, ERR on a missing ack).
module node_mu_ctrl
  import node_mu_ctrl_pkg::*;
#(
  parameter int               WIDTH    = NODE_WIDTH,
  parameter logic [WIDTH-1:0] MAX_ITER = {WIDTH{1'b1}},
  parameter int               ACK_TO   = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  output logic             RD,
  output logic [WIDTH-1:0] RES,
  output logic             OVF,
  output logic             ERR,
  output logic             C_ST,
  output logic [WIDTH-1:0] C_Y,
  input  logic             C_RD,
  input  logic [WIDTH-1:0] C_RES
);

  localparam int            TW       = $clog2(ACK_TO + 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TO - 1);

  node_state_t      state, stateN;
  logic             rd, rdN, ovf, ovfN, err, errN, cSt, cStN;
  logic [WIDTH-1:0] res, resN, cY, cYN, cap, capN;
  logic [TW-1:0]    ackTmr, ackTmrN, ackElapsed;
  logic             stRise, cStRise;

  // Previous ST reads as high after reset, so a start held across reset release is not a fresh edge.
  node_mu_ctrl_st_edge #(.RESET_VAL(1'b1)) stEdge (
    .CLK (CLK),
    .RST (RST),
    .d   (ST),
    .rise(stRise)
  );

  // The C_ST rising edge marks the first WAIT_ACK cycle and restarts the ack timer.
  node_mu_ctrl_st_edge #(.RESET_VAL(1'b0)) cStEdge (
    .CLK (CLK),
    .RST (RST),
    .d   (cSt),
    .rise(cStRise)
  );

  assign ackElapsed = cStRise ? '0 : ackTmr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      rd     <= 1'b1;
      res    <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      cSt    <= 1'b0;
      cY     <= '0;
      cap    <= '0;
      ackTmr <= '0;
    end else begin
      state  <= stateN;
      rd     <= rdN;
      res    <= resN;
      ovf    <= ovfN;
      err    <= errN;
      cSt    <= cStN;
      cY     <= cYN;
      cap    <= capN;
      ackTmr <= ackTmrN;
    end
  end

  always_comb begin
    stateN  = state;
    rdN     = rd;
    resN    = res;
    ovfN    = ovf;
    errN    = err;
    cStN    = cSt;
    cYN     = cY;
    capN    = cap;
    ackTmrN = ackTmr;
    if (stRise && state != IDLE) begin
      // A new upstream edge aborts the search; GAP guarantees the child sees C_ST low first.
      cYN    = '0;
      ovfN   = 1'b0;
      errN   = 1'b0;
      rdN    = 1'b0;
      cStN   = 1'b0;
      stateN = GAP;
    end else begin
      case (state)
        IDLE: begin
          if (stRise) begin
            rdN    = 1'b0;
            ovfN   = 1'b0;
            errN   = 1'b0;
            cYN    = '0;
            stateN = LAUNCH;
          end
        end
        LAUNCH: begin
          cStN   = 1'b1;
          stateN = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!C_RD) begin
            cStN   = 1'b0;
            stateN = WAIT_DONE;
          end else if (ackElapsed == ACK_LAST) begin
            cStN   = 1'b0;
            errN   = 1'b1;
            rdN    = 1'b1;
            resN   = cY;
            stateN = IDLE;
          end else begin
            ackTmrN = ackElapsed + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (C_RD) begin
            capN   = C_RES;
            stateN = EVAL;
          end
        end
        EVAL: begin
          if (cap == '0) begin
            resN   = cY;
            rdN    = 1'b1;
            stateN = IDLE;
          end else if (cY == MAX_ITER) begin
            resN   = cY;
            ovfN   = 1'b1;
            rdN    = 1'b1;
            stateN = IDLE;
          end else begin
            cYN    = cY + WIDTH'(1);
            stateN = LAUNCH;
          end
        end
        GAP:     stateN = LAUNCH;
        default: stateN = IDLE;
      endcase
    end
  end

  assign RD   = rd;
  assign RES  = res;
  assign OVF  = ovf;
  assign ERR  = err;
  assign C_ST = cSt;
  assign C_Y  = cY;

endmodule

// File: tb/tb_node_mu_ctrl.sv
// Self-checking bench for node_mu_ctrl: behavioural child, timeline model of the
// expected outputs, and directed scenarios with literal expectations.
module tb_node_mu_ctrl;

  localparam int W        = 16;
  localparam int MAX_IT   = 4;
  localparam int ACK_TO   = 15;

  typedef enum int {M_SUB3, M_ZERO, M_ONES, M_NOACK} mode_t;

  typedef struct {
    int           len;
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    mode_t        m;
  } plan_t;

  logic         CLK, RST, ST, RD, OVF, ERR, C_ST, C_RD;
  logic [W-1:0] RES, C_Y, C_RES;

  mode_t mode;
  int    total = 0;
  int    bad   = 0;
  int    cStRises = 0;
  int    hiCnt = 0;

  node_mu_ctrl #(.WIDTH(W), .MAX_ITER(W'(MAX_IT)), .ACK_TO(ACK_TO)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ST   (ST),
    .RD   (RD),
    .RES  (RES),
    .OVF  (OVF),
    .ERR  (ERR),
    .C_ST (C_ST),
    .C_Y  (C_Y),
    .C_RD (C_RD),
    .C_RES(C_RES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge C_ST) cStRises++;

  function automatic logic [W-1:0] childFn(input logic [W-1:0] y, input mode_t m);
    case (m)
      M_SUB3:  return y - W'(3);
      M_ZERO:  return '0;
      default: return W'(1);
    endcase
  endfunction

  // Child node: drops RD one cycle after seeing C_ST rise, raises it two cycles later.
  int   childCnt;
  logic cStPrev;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      C_RD     <= 1'b1;
      C_RES    <= '0;
      childCnt <= 0;
      cStPrev  <= 1'b0;
    end else begin
      cStPrev <= C_ST;
      if (mode != M_NOACK && C_ST && !cStPrev) begin
        C_RD     <= 1'b0;
        childCnt <= 2;
      end else if (childCnt == 1) begin
        C_RD     <= 1'b1;
        C_RES    <= childFn(C_Y, mode);
        childCnt <= 0;
      end else if (childCnt > 1) begin
        childCnt <= childCnt - 1;
      end
    end
  end

  // Outcome of a whole search: answer, flags, and edges from the start edge to RD=1.
  function automatic plan_t planSearch(input mode_t m);
    plan_t p;
    bit    found;
    p.m   = m;
    p.ovf = 1'b0;
    p.err = 1'b0;
    p.res = '0;
    if (m == M_NOACK) begin
      p.err = 1'b1;
      p.len = 1 + ACK_TO;
    end else begin
      found = 1'b0;
      for (int y = 0; y <= MAX_IT && !found; y++) begin
        if (childFn(W'(y), m) == '0) begin
          found = 1'b1;
          p.res = W'(y);
        end
      end
      if (!found) begin
        p.res = W'(MAX_IT);
        p.ovf = 1'b1;
      end
      p.len = 6 * (int'(p.res) + 1);
    end
    return p;
  endfunction

  int    edgeCnt = 0;
  int    anchor  = 0;
  bit    active  = 1'b0;
  logic  prevSt  = 1'b1;
  plan_t plan;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      active <= 1'b0;
      prevSt <= 1'b1;
    end else begin
      edgeCnt <= edgeCnt + 1;
      prevSt  <= ST;
      if (ST && !prevSt) begin
        active <= 1'b1;
        plan   <= planSearch(mode);
        if (active && (edgeCnt + 1 - anchor) >= 1 && (edgeCnt + 1 - anchor) <= plan.len)
          anchor <= edgeCnt + 2;
        else
          anchor <= edgeCnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    int           t, tc;
    logic         eRd, eOvf, eErr, eCst;
    logic [W-1:0] eRes, eCy;
    eRes = '0;
    eOvf = 1'b0;
    eErr = 1'b0;
    eCst = 1'b0;
    eCy  = '0;
    eRd  = 1'b1;
    if (active) begin
      t = edgeCnt - anchor;
      if (t >= plan.len) begin
        eRes = plan.res;
        eOvf = plan.ovf;
        eErr = plan.err;
        eCy  = plan.res;
      end else begin
        tc  = (t < 0) ? 0 : t;
        eRd = 1'b0;
        if (plan.m == M_NOACK) begin
          eCst = (tc >= 1);
        end else begin
          eCst = (tc % 6 == 1) || (tc % 6 == 2);
          eCy  = W'(tc / 6);
        end
      end
    end
    checkOutput("modelRd", RD, eRd);
    checkOutput("modelOvf", OVF, eOvf);
    checkOutput("modelErr", ERR, eErr);
    checkOutput("modelCst", C_ST, eCst);
    checkOutput("modelCy", C_Y, eCy);
    if (eRd) checkOutput("modelRes", RES, eRes);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) compareAll();
    end
  end

  // Called just after a clock edge; the next edge samples the ST rise.
  task automatic applyStimulus();
    ST = 1'b1;
    @(posedge CLK);
    #1;
    ST = 1'b0;
  endtask

  // Counts edges from the start edge (counted as 1) until RD returns high.
  task automatic waitReady(output int cnt);
    cnt   = 1;
    hiCnt = 0;
    while (!RD && cnt < 300) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (C_ST) hiCnt++;
    end
    checkOutput("rdTimeout", RD, 1);
  endtask

  int cnt, rises0, steps;

  initial begin
    RST  = 1'b0;
    ST   = 1'b0;
    mode = M_SUB3;
    #12;
    checkOutput("rstRd", RD, 1);
    checkOutput("rstRes", RES, 0);
    checkOutput("rstOvf", OVF, 0);
    checkOutput("rstErr", ERR, 0);
    checkOutput("rstCst", C_ST, 0);
    checkOutput("rstCy", C_Y, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] answer 3 search");
    mode = M_SUB3;
    applyStimulus();
    checkOutput("startRd", RD, 0);
    waitReady(cnt);
    checkOutput("sub3Lat", cnt, 25);
    checkOutput("sub3Res", RES, 3);
    checkOutput("sub3Ovf", OVF, 0);
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] zero on first try");
    mode   = M_ZERO;
    rises0 = cStRises;
    applyStimulus();
    waitReady(cnt);
    checkOutput("zeroLat", cnt, 7);
    checkOutput("zeroRes", RES, 0);
    checkOutput("zeroStarts", cStRises - rises0, 1);
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] overflow");
    mode   = M_ONES;
    rises0 = cStRises;
    applyStimulus();
    waitReady(cnt);
    checkOutput("ovfLat", cnt, 31);
    checkOutput("ovfStarts", cStRises - rises0, 5);
    checkOutput("ovfRes", RES, 4);
    checkOutput("ovfFlag", OVF, 1);
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] missing ack");
    mode = M_NOACK;
    applyStimulus();
    waitReady(cnt);
    checkOutput("ackLat", cnt, 17);
    checkOutput("ackHigh", hiCnt, ACK_TO);
    checkOutput("ackErr", ERR, 1);
    checkOutput("ackRes", RES, 0);
    checkOutput("ackCst", C_ST, 0);
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] restart during WAIT_DONE of Y=2");
    mode = M_SUB3;
    applyStimulus();
    steps = 0;
    while (!(C_Y == W'(2) && !C_ST && !C_RD) && steps < 100) begin
      @(posedge CLK);
      #1;
      steps++;
    end
    checkOutput("y2Reached", C_Y, 2);
    applyStimulus();
    checkOutput("rstrtCst", C_ST, 0);
    checkOutput("rstrtCy", C_Y, 0);
    checkOutput("rstrtRd", RD, 0);
    waitReady(cnt);
    checkOutput("rstrtLat", cnt, 26);
    checkOutput("rstrtRes", RES, 3);
    repeat (3) @(posedge CLK);
    #1;

    $display("[TB] async reset in WAIT_ACK");
    mode = M_NOACK;
    applyStimulus();
    @(posedge CLK);
    #1;
    checkOutput("preRstCst", C_ST, 1);
    #1;
    RST = 1'b0;
    ST  = 1'b1;
    #1;
    checkOutput("asyncCst", C_ST, 0);
    checkOutput("asyncRd", RD, 1);
    checkOutput("asyncCy", C_Y, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("heldRd", RD, 1);
    checkOutput("heldCst", C_ST, 0);
    ST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    mode = M_ZERO;
    applyStimulus();
    waitReady(cnt);
    checkOutput("postRstLat", cnt, 7);
    repeat (2) @(posedge CLK);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
